// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer and its FIFO.
//   state_t  : serializer FSM state encoding
//   level_w  : width needed to hold a FIFO occupancy of 0..depth
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   push, wr_data    write request and data (ignored while full)
//   pop, rd_data     read request (ignored while empty); rd_data shows the head
//   full, empty      derived from level
//   level            number of stored words
module sync_fifo
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage has no reset; only entries written by an accepted push are ever read.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: buffers words in a FIFO and streams them out
// one bit per clock with no gaps between queued words; idle fill otherwise.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready = FIFO not full)
//   in_data               word to serialize
//   bit_stream            registered serial bit (IDLE_BIT when idle)
//   bit_valid             registered, high while bit_stream carries data
//   underrun              registered pulse when data runs out into idle fill
//   fifo_level            queued words, excluding the one in the shifter
//
// state | meaning
// IDLE  | no word in shifter, driving IDLE_BIT
// SHIFT | a word is being shifted out, bit_cnt bits already driven
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   DEPTH     = 4,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        bit_stream,
  output logic                        bit_valid,
  output logic                        underrun,
  output logic [level_w(DEPTH)-1:0]   fifo_level
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             bit_d, valid_d, under_d;
  logic             pop;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head;

  // Ready depends on full only; a same-cycle pop does not open a slot.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    bit_d   = bit_stream;
    valid_d = bit_valid;
    under_d = 1'b0;
    pop     = 1'b0;

    if (state_q == SHIFT && cnt_q != CNT_W'(WIDTH)) begin
      sreg_d  = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
      bit_d   = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
      cnt_d   = cnt_q + 1'b1;
    end else if (!fifo_empty) begin
      // Word boundary (or idle) with data queued: load and emit its first bit.
      pop     = 1'b1;
      sreg_d  = head;
      bit_d   = MSB_FIRST ? head[WIDTH-1] : head[0];
      valid_d = 1'b1;
      cnt_d   = CNT_W'(1);
      state_d = SHIFT;
    end else begin
      bit_d   = IDLE_BIT;
      valid_d = 1'b0;
      under_d = (state_q == SHIFT);
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sreg_q     <= '0;
      bit_stream <= IDLE_BIT;
      bit_valid  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      bit_stream <= bit_d;
      bit_valid  <= valid_d;
      underrun   <= under_d;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_bit_serializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;

  logic             rdy_m, bs_m, bv_m, ur_m;
  logic             rdy_l, bs_l, bv_l, ur_l;
  logic [LVL_W-1:0] lvl_m, lvl_l;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  bit_serializer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m),
    .in_data(in_data), .bit_stream(bs_m), .bit_valid(bv_m),
    .underrun(ur_m), .fifo_level(lvl_m)
  );

  bit_serializer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)
  ) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_l),
    .in_data(in_data), .bit_stream(bs_l), .bit_valid(bv_l),
    .underrun(ur_l), .fifo_level(lvl_l)
  );

  // Reference: queue of pending words, and per-order queues of bits still to send.
  logic [WIDTH-1:0] q_words [$];
  bit               rem_m [$];
  bit               rem_l [$];
  bit               e_bit_m, e_bit_l, e_valid, e_under;

  task automatic model_step();
    bit               acc;
    logic [WIDTH-1:0] w;
    acc = in_valid && (q_words.size() < DEPTH);
    if (!rst_n) begin
      q_words.delete();
      rem_m.delete();
      rem_l.delete();
      e_bit_m = 1'b0;
      e_bit_l = 1'b0;
      e_valid = 1'b0;
      e_under = 1'b0;
      return;
    end
    if (rem_m.size() == 0 && q_words.size() > 0) begin
      w = q_words.pop_front();
      for (int i = 0; i < WIDTH; i++) begin
        rem_m.push_back(w[WIDTH-1-i]);
        rem_l.push_back(w[i]);
      end
    end
    if (rem_m.size() > 0) begin
      e_bit_m = rem_m.pop_front();
      e_bit_l = rem_l.pop_front();
      e_valid = 1'b1;
      e_under = 1'b0;
    end else begin
      e_under = e_valid;
      e_valid = 1'b0;
      e_bit_m = 1'b0;
      e_bit_l = 1'b0;
    end
    if (acc) q_words.push_back(in_data);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle(input logic rv, input logic v, input logic [WIDTH-1:0] d);
    rst_n    = rv;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("bit_m",   32'(bs_m),  32'(e_bit_m));
    chk("valid_m", 32'(bv_m),  32'(e_valid));
    chk("under_m", 32'(ur_m),  32'(e_under));
    chk("level_m", 32'(lvl_m), 32'(q_words.size()));
    chk("ready_m", 32'(rdy_m), 32'(q_words.size() < DEPTH));
    chk("bit_l",   32'(bs_l),  32'(e_bit_l));
    chk("valid_l", 32'(bv_l),  32'(e_valid));
    chk("under_l", 32'(ur_l),  32'(e_under));
    chk("level_l", 32'(lvl_l), 32'(q_words.size()));
  endtask

  initial begin
    logic [WIDTH-1:0] cap_m, cap_l;
    logic [15:0]      cap16;
    logic             any_ur, any_v;
    int               dens;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    e_bit_m  = 1'b0;
    e_bit_l  = 1'b0;
    e_valid  = 1'b0;
    e_under  = 1'b0;

    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h3C);
    chk("rst_ready", 32'(rdy_m), 32'd1);
    chk("rst_level", 32'(lvl_m), 32'd0);
    chk("rst_valid", 32'(bv_m), 32'd0);

    // Single word 8'hA5: bits in both orders, then one underrun pulse.
    cycle(1'b1, 1'b1, 8'hA5);
    cap_m = '0; cap_l = '0; any_v = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cycle(1'b1, 1'b0, 8'($urandom));
      cap_m    = {cap_m[WIDTH-2:0], bs_m};
      cap_l[i] = bs_l;
      any_v    = any_v & bv_m;
    end
    chk("a5_msb_bits", 32'(cap_m), 32'h00A5);
    chk("a5_lsb_bits", 32'(cap_l), 32'h00A5);
    chk("a5_all_valid", 32'(any_v), 32'd1);
    cycle(1'b1, 1'b0, '0);
    chk("a5_underrun", 32'(ur_m), 32'd1);
    chk("a5_idle_bit", 32'(bs_m), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("a5_underrun_once", 32'(ur_m), 32'd0);

    // Back-to-back F0, 0F: 16 contiguous data bits.
    cycle(1'b1, 1'b1, 8'hF0);
    cycle(1'b1, 1'b1, 8'h0F);
    cap16 = {15'd0, bs_m};
    any_ur = 1'b0;
    for (int i = 1; i < 16; i++) begin
      cycle(1'b1, 1'b0, '0);
      cap16  = {cap16[14:0], bs_m};
      any_ur = any_ur | ur_m | !bv_m;
    end
    chk("b2b_bits", 32'(cap16), 32'h0000F00F);
    chk("b2b_no_gap", 32'(any_ur), 32'd0);
    cycle(1'b1, 1'b0, '0);
    chk("b2b_underrun", 32'(ur_m), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);

    // Backpressure: hold in_valid from idle.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'($urandom));
    chk("bp_level_full", 32'(lvl_m), 32'd4);
    chk("bp_not_ready", 32'(rdy_m), 32'd0);
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0, '0);

    // Reset while bit 3 of A5 is on the wire with two words queued.
    cycle(1'b1, 1'b1, 8'hA5);
    cycle(1'b1, 1'b1, 8'h55);
    cycle(1'b1, 1'b1, 8'h33);
    cycle(1'b1, 1'b0, '0);
    chk("mid_level_pre", 32'(lvl_m), 32'd2);
    cycle(1'b0, 1'b0, '0);
    chk("mid_valid", 32'(bv_m), 32'd0);
    chk("mid_level", 32'(lvl_m), 32'd0);
    chk("mid_ready", 32'(rdy_m), 32'd1);
    chk("mid_under", 32'(ur_m), 32'd0);
    any_v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, '0);
      any_v = any_v | bv_m | bv_l | ur_m;
    end
    chk("mid_no_resume", 32'(any_v), 32'd0);

    // Random traffic with varying density and rare resets.
    dens = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) dens = $urandom_range(5, 100);
      cycle($urandom_range(0, 299) != 0,
            $urandom_range(0, 99) < dens,
            8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Upstream feeder for the pattern detector. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. It then shifts them out as a continuous one-bit-per-cycle stream on bit_stream, with no gaps between queued words. When no data is queued, it drives a fixed idle bit so the downstream detector always sees a defined level.

Parameters:
WIDTH, 8, bits per input word (>=2)
DEPTH, 4, FIFO entries, not counting the word held in the shifter (>=2, power of 2)
MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = bit 0 first
IDLE_BIT, 1'b0, value driven on bit_stream when no word is being shifted

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  upstream word valid
in_ready  out  1  FIFO can accept; equals !full
in_data  in  WIDTH  word to serialize
bit_stream  out  1  registered serial output; connects to the detector's bit_stream
bit_valid  out  1  registered; high while bit_stream carries a data bit
underrun  out  1  registered one-cycle pulse when the stream drops from data to idle fill
fifo_level  out  $clog2(DEPTH+1)  number of queued words, excluding the shifter

Behaviour:
- Reset (rst_n low at a clk edge): FIFO is emptied and fifo_level=0. State is IDLE, bit_cnt=0, bit_stream=IDLE_BIT, bit_valid=0, underrun=0, in_ready=1.
- Reset mid-word discards the partial word and all queued words. No underrun pulse is produced.
- Push: a word is written on an edge where in_valid && in_ready.
- Push while full is not accepted. in_ready is derived from full only, so a pop in the same cycle does not free a slot for that cycle.
- Pop and push in the same edge: fifo_level stays unchanged.
- FSM states are IDLE and SHIFT. bit_cnt counts the bits already driven from the current word (0..WIDTH).
- IDLE edge with FIFO empty: stay in IDLE, drive bit_stream=IDLE_BIT and bit_valid=0.
- IDLE edge with FIFO non-empty: pop the head into shift_reg and drive its first bit. Set bit_valid=1, bit_cnt=1, and go to SHIFT.
- SHIFT edge with bit_cnt<WIDTH: drive the next bit in shift order and increment bit_cnt.
- SHIFT edge with bit_cnt==WIDTH and FIFO non-empty: pop and drive the first bit of the new word, set bit_cnt=1, stay in SHIFT. There is no gap cycle between words.
- SHIFT edge with bit_cnt==WIDTH and FIFO empty: drive IDLE_BIT, set bit_valid=0 and underrun=1 for one cycle, go to IDLE.
- Latency: a word accepted at edge E into an empty FIFO with the FSM in IDLE is popped at edge E+1. Its first bit is visible from E+1 to E+2, and its last bit from E+WIDTH to E+WIDTH+1.
- Bit order: shift_reg shifts left when MSB_FIRST=1 and right when MSB_FIRST=0. The output bit is taken from bit WIDTH-1 or bit 0 respectively.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. full and empty come from fifo_level (DEPTH and 0 respectively).
- in_data is sampled only on accepted handshakes. X on in_data while in_valid=0 must never propagate.

Decomposition:
- Package bit_serializer_pkg: state enum typedef (IDLE, SHIFT) and a localparam function for level width, $clog2(DEPTH+1).
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop, full, empty, level, synchronous active-low reset. bit_serializer instantiates one sync_fifo plus the shift FSM.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1: push 8'hA5 at edge E -> bit_stream reads 1,0,1,0,0,1,0,1 with bit_valid=1 for cycles E+1..E+8. underrun=1 for exactly one cycle after the last bit, then bit_stream=IDLE_BIT.
- Back-to-back: push 8'hF0 then 8'h0F on consecutive edges -> 16 contiguous valid bits 1111000000001111. No underrun until after bit 16.
- Backpressure, DEPTH=4: hold in_valid=1 from idle -> 5 words accepted (edges 1-5), fifo_level=4, in_ready=0 from edge 5 onward. in_ready returns to 1 the cycle after the next pop.
- LSB-first, MSB_FIRST=0: push 8'h01 -> bits 1,0,0,0,0,0,0,0.
- Reset mid-word: assert rst_n low while bit 3 of 8'hA5 is on the output, with 2 words queued -> next cycle bit_valid=0, bit_stream=IDLE_BIT, fifo_level=0, in_ready=1, underrun=0. Nothing resumes after release.
- Integration with the detector (PATTERN 4'b1010): push 8'h0A -> detector found asserts after the stream 0,0,0,0,1,0,1,0 completes. Idle fill of all IDLE_BIT=0 never asserts found.
